// File: rtl/bus_ram.sv
`default_nettype none
// ============================================================================
//  Module   : bus_ram
//  Purpose  : Word-addressed single-port RAM responder on the memory bus.
//             It has programmable wait states and byte-masked writes.
//  Revision : 1.0
// ============================================================================
module bus_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        read_in,
    input  logic        write_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [3:0]    mask_q, mask_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic          w_req;
    logic          w_complete;
    logic          w_unused_addr;

    assign w_req         = read_in | write_in;
    assign w_unused_addr = ^{address_in[31:AW+2], address_in[1:0]};

    // The *_d transaction fields are the live inputs when completing straight
    // out of IDLE and the latched copy otherwise.
    // cnt holds the number of BUSY cycles still to follow the current one.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        mask_d     = mask_q;
        wdata_d    = wdata_q;
        w_complete = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_req) begin
                    idx_d   = address_in[AW+1:2];
                    rd_d    = read_in;
                    wr_d    = write_in;
                    mask_d  = write_mask_in;
                    wdata_d = write_value_in;
                    if (WAIT_STATES == 0) begin
                        w_complete = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            BUSY: begin
                if (!w_req) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    w_complete = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_complete) begin
            state_d = RESP;
        end
        ready_d = w_complete;
        rdata_d = (w_complete && rd_d) ? mem[idx_d] : 32'h0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            mask_q  <= 4'h0;
            wdata_q <= 32'h0;
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is never cleared; the reset gate keeps a clock edge seen while
    // reset is held from committing a write.
    always_ff @(posedge clk) begin
        if (w_complete && wr_d && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_d[b]) begin
                    mem[idx_d][8*b +: 8] <= wdata_d[8*b +: 8];
                end
            end
        end
    end

    assign ready_out      = ready_q;
    assign read_value_out = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_ram
//  Purpose  : Self-checking bench for bus_ram with two instances,
//             WAIT_STATES 0 and 2, both with 16 words.
//  Revision : 1.0
// ============================================================================
module tb_bus_ram;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr  [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [3:0]  mask  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ready [2];

    always #5 clk = ~clk;

    bus_ram #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut_w0 (
        .clk(clk), .reset(reset), .address_in(addr[0]), .read_in(rd[0]),
        .write_in(wr[0]), .read_value_out(rdata[0]), .write_mask_in(mask[0]),
        .write_value_in(wdata[0]), .ready_out(ready[0])
    );

    bus_ram #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u_dut_w2 (
        .clk(clk), .reset(reset), .address_in(addr[1]), .read_in(rd[1]),
        .write_in(wr[1]), .read_value_out(rdata[1]), .write_mask_in(mask[1]),
        .write_value_in(wdata[1]), .ready_out(ready[1])
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mdl [2][DEPTH];

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [3:0]  m;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [13];

    function automatic int ws(input int k);
        return (k == 1) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference memory: returns the data a transaction should deliver and
    // applies its byte-masked write.
    function automatic logic [31:0] model_txn(input int k, input bit r, input bit w,
                                              input logic [31:0] a, input logic [3:0] m,
                                              input logic [31:0] d);
        int          i;
        logic [31:0] old;
        logic [31:0] keep;
        i    = int'(a[5:2]);
        old  = mdl[k][i];
        keep = 32'h0;
        if (w) begin
            for (int b = 0; b < 4; b++) begin
                if (m[b]) keep[8*b +: 8] = 8'hFF;
            end
            mdl[k][i] = (old & ~keep) | (d & keep);
        end
        return r ? old : 32'h0;
    endfunction

    // Called just after a falling edge; returns at a falling edge with the DUT idle.
    task automatic txn(input int k, input bit r, input bit w, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] d, output logic [31:0] got);
        bit seen;
        chk("ready_low_before_request", 32'(ready[k]), 32'h0);
        rd[k] = r; wr[k] = w; addr[k] = a; mask[k] = m; wdata[k] = d;
        seen = 1'b0;
        got  = 32'h0;
        for (int c = 1; c <= ws(k) + 5 && !seen; c++) begin
            @(negedge clk);
            if (ready[k] === 1'b1) begin
                seen = 1'b1;
                chk("ready_cycle", 32'(c), 32'(ws(k) + 1));
                got   = rdata[k];
                rd[k] = 1'b0;
                wr[k] = 1'b0;
            end
        end
        if (!seen) begin
            chk("ready_timeout", 32'h0, 32'h1);
            rd[k] = 1'b0;
            wr[k] = 1'b0;
        end
        @(negedge clk);
        chk("ready_single_pulse", 32'(ready[k]), 32'h0);
        chk("rdata_zero_after_resp", rdata[k], 32'h0);
    endtask

    task automatic run_check(input int k, input bit r, input bit w, input logic [31:0] a,
                             input logic [3:0] m, input logic [31:0] d, input string name);
        logic [31:0] exp;
        logic [31:0] got;
        exp = model_txn(k, r, w, a, m, d);
        txn(k, r, w, a, m, d, got);
        chk(name, got, exp);
    endtask

    task automatic b2b(input int k, input logic [31:0] a);
        int          last;
        int          pulses;
        int          gap;
        logic        prev;
        logic [31:0] exp;
        exp    = mdl[k][int'(a[5:2])];
        last   = 0;
        pulses = 0;
        prev   = 1'b0;
        rd[k] = 1'b1; wr[k] = 1'b0; addr[k] = a;
        for (int c = 1; c <= 4 * (ws(k) + 3); c++) begin
            @(negedge clk);
            if (ready[k] === 1'b1) begin
                chk("b2b_not_consecutive", 32'(prev), 32'h0);
                chk("b2b_rdata", rdata[k], exp);
                if (pulses == 0) begin
                    chk("b2b_first_ready", 32'(c), 32'(ws(k) + 1));
                end else begin
                    gap = c - last;
                    chk("b2b_gap_in_range", 32'(gap >= ws(k) + 2 && gap <= ws(k) + 3), 32'h1);
                end
                pulses++;
                last = c;
            end
            prev = ready[k];
        end
        chk("b2b_pulse_count", 32'(pulses >= 3), 32'h1);
        rd[k] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_idle_after_drop", 32'(ready[k]), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] old;
        bit          r;
        bit          w;

        tbl[0]  = '{1'b0, 1'b1, 32'h10,  4'hF, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h10,  4'h0, 32'h0,        32'hDEADBEEF};
        tbl[2]  = '{1'b1, 1'b0, 32'h12,  4'h0, 32'h0,        32'hDEADBEEF};
        tbl[3]  = '{1'b0, 1'b1, 32'h40,  4'hF, 32'h11223344, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 32'h40,  4'h5, 32'hAABBCCDD, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 32'h40,  4'h0, 32'h0,        32'h11BB33DD};
        tbl[6]  = '{1'b0, 1'b1, 32'h40,  4'h0, 32'hFFFFFFFF, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 32'h40,  4'h0, 32'h0,        32'h11BB33DD};
        tbl[8]  = '{1'b1, 1'b1, 32'h10,  4'hF, 32'h0,        32'hDEADBEEF};
        tbl[9]  = '{1'b1, 1'b0, 32'h10,  4'h0, 32'h0,        32'h0};
        tbl[10] = '{1'b0, 1'b1, 32'h0,   4'hF, 32'h12345678, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 32'h40,  4'h0, 32'h0,        32'h12345678};
        tbl[12] = '{1'b1, 1'b0, 32'h3C0, 4'h0, 32'h0,        32'h12345678};

        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = 32'h0; mask[k] = 4'h0; wdata[k] = 32'h0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_ready", 32'(ready[k]), 32'h0);
            chk("reset_rdata", rdata[k], 32'h0);
        end
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                run_check(k, 1'b0, 1'b1, 32'(i * 4), 4'hF, $urandom, "preload");
            end
            for (int i = 0; i < 13; i++) begin
                void'(model_txn(k, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].m, tbl[i].d));
                txn(k, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].m, tbl[i].d, got);
                chk($sformatf("table_vec%0d_dut%0d", i, k), got, tbl[i].exp);
            end
            for (int i = 0; i < 30; i++) begin
                r = 1'($urandom_range(0, 1));
                w = 1'($urandom_range(0, 1));
                if (!r && !w) r = 1'b1;
                run_check(k, r, w, $urandom, 4'($urandom_range(0, 15)), $urandom, "random_txn");
            end
        end

        // Abort: request dropped right before the completion edge.
        run_check(1, 1'b0, 1'b1, 32'h20, 4'hF, 32'h0, "abort_setup");
        wr[1] = 1'b1; rd[1] = 1'b0; addr[1] = 32'h20; mask[1] = 4'hF; wdata[1] = 32'hFFFFFFFF;
        @(negedge clk);
        chk("abort_ready_c1", 32'(ready[1]), 32'h0);
        @(negedge clk);
        chk("abort_ready_c2", 32'(ready[1]), 32'h0);
        wr[1] = 1'b0;
        for (int c = 3; c < 7; c++) begin
            @(negedge clk);
            chk("abort_no_ready", 32'(ready[1]), 32'h0);
        end
        run_check(1, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, "abort_word_unchanged");

        // Inputs changed mid-BUSY while still requesting: latched values win.
        wr[1] = 1'b1; rd[1] = 1'b0; addr[1] = 32'h18; mask[1] = 4'hF; wdata[1] = 32'h5A5A0001;
        @(negedge clk);
        addr[1] = 32'h1C; mask[1] = 4'h3; wdata[1] = 32'hFFFF0000; rd[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("latched_ready", 32'(ready[1]), 32'h1);
        chk("latched_pure_write_rdata", rdata[1], 32'h0);
        wr[1] = 1'b0; rd[1] = 1'b0;
        @(negedge clk);
        void'(model_txn(1, 1'b0, 1'b1, 32'h18, 4'hF, 32'h5A5A0001));
        run_check(1, 1'b1, 1'b0, 32'h18, 4'h0, 32'h0, "latched_target_written");
        run_check(1, 1'b1, 1'b0, 32'h1C, 4'h0, 32'h0, "latched_other_untouched");

        // Reset asserted between edges during the response cycle.
        run_check(1, 1'b0, 1'b1, 32'h08, 4'hF, 32'hCAFEF00D, "rst_resp_setup");
        rd[1] = 1'b1; addr[1] = 32'h08;
        for (int c = 1; c <= 3; c++) @(negedge clk);
        chk("rst_resp_ready_before", 32'(ready[1]), 32'h1);
        chk("rst_resp_rdata_before", rdata[1], 32'hCAFEF00D);
        #2 reset = 1'b1;
        #1;
        chk("rst_resp_ready_async", 32'(ready[1]), 32'h0);
        chk("rst_resp_rdata_async", rdata[1], 32'h0);
        rd[1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset asserted mid-write in BUSY: the write must never land.
        old   = mdl[1][5];
        wr[1] = 1'b1; addr[1] = 32'h14; mask[1] = 4'hF; wdata[1] = ~old;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_busy_ready_async", 32'(ready[1]), 32'h0);
        chk("rst_busy_rdata_async", rdata[1], 32'h0);
        @(negedge clk);
        wr[1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_check(1, 1'b1, 1'b0, 32'h14, 4'h0, 32'h0, "rst_target_kept");
        run_check(1, 1'b1, 1'b0, 32'h08, 4'h0, 32'h0, "rst_other_kept");
        run_check(0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, "rst_dut0_kept");

        b2b(0, 32'h40);
        b2b(1, 32'h08);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
